uart_frame_cmd_ctrl: RTL and testbench
======================================

// Module: uart_frame_cmd_ctrl
// PURPOSE
// Byte-command controller between the UART core (rx/tx byte handshakes) and a single-port frame RAM.
// Parametrised successor of the fixed 15-bit/19200-byte command controller.
// Adds: 16-bit address load, write with auto-increment, tx_ready-paced bursts, wrap at DEPTH, binary-safe data bytes.
// Sits between the UART core and the camera frame buffer.
// PARAMETERS
// ADDR_W     15     RAM address width; also burst counter width
// DEPTH      19200  RAM words used; address wraps DEPTH-1 -> 0 (DEPTH <= 2**ADDR_W)
// SHORT_LEN  100    bytes sent by 0xCC burst
// GAP_CYC    255    minimum idle cycles between burst bytes (0 = back-to-back on tx_ready)
// PORTS
// clk        in   1       system clock
// rst        in   1       asynchronous active-high reset
// rx_valid   in   1       1-cycle pulse: rx_data holds a received byte
// rx_data    in   8       received byte
// tx_ready   in   1       UART transmitter idle, can accept tx_start
// tx_start   out  1       1-cycle pulse: transmit tx_data
// tx_data    out  8       byte to transmit, stable from tx_start until next tx_start
// ram_addr   out  ADDR_W  RAM address (= internal pointer)
// ram_wdata  out  8       RAM write data
// ram_we     out  1       1-cycle RAM write strobe
// ram_rdata  in   8       RAM read data, valid 1 clk after ram_addr changes
// busy       out  1       high in any state other than IDLE
// BEHAVIOUR
// Reset (async, any state):
// - Pointer = 0, state = IDLE.
// - tx_start = 0, tx_data = 0, ram_we = 0, ram_wdata = 0, busy = 0.
// IDLE commands (on rx_valid):
// - 0x00: pointer = 0.
// - 0xBB: pointer + 1, with wrap.
// - 0xFF: send pointer[7:0].
// - 0xFE: send {pointer[ADDR_W-1:8], zero-padded}.
// - 0xA5: go to ADDR_LO. Next byte loads pointer[7:0] -> ADDR_HI. Next byte loads the upper bits.
//   If the loaded value >= DEPTH, pointer = 0.
// - 0xDD: go to WR_DATA. Next byte is written at the pointer (WR_COMMIT: ram_we = 1 for 1 clk).
//   Pointer + 1 (wrap) in the following clk, then IDLE.
// - 0xAA: RD_WAIT (1 clk), then send ram_rdata. Pointer is unchanged.
// - 0xCC: burst of SHORT_LEN bytes. 0x33: burst of DEPTH bytes.
// - Any other byte is ignored.
// Send (single byte or burst byte):
// - TX_WAIT holds until tx_ready = 1.
// - Then tx_start pulses 1 clk with tx_data latched, and the block returns to IDLE (single byte only).
// Burst (BURST_RD -> BURST_TX -> BURST_GAP):
// - Load count = len-1. BURST_RD waits 1 clk for ram_rdata. BURST_TX waits for tx_ready, then sends ram_rdata.
// - In the send clk: pointer + 1 (wrap); if count == 0 -> IDLE, else count - 1 -> BURST_GAP.
// - BURST_GAP idles GAP_CYC clks, then -> BURST_RD.
// - The pointer ends one past the last byte sent.
// Abort:
// - 0x55 in any BURST_* or TX_WAIT state -> IDLE next clk. No further tx_start.
// - Abort takes priority over a same-cycle send.
// - In WR_DATA/ADDR_LO/ADDR_HI, 0x55 is data (binary safe).
// - Other rx bytes while busy are ignored.
// Invariants:
// - tx_start and ram_we are never high in consecutive clks.
// - The pointer is never >= DEPTH.
// TESTING
// - 0xA5,0x10,0x00; 0xDD,0x5A; 0xFF -> ram_we once at addr 0x0010 with data 0x5A; tx 0x11.
// - Write 0x55 via 0xDD,0x55 at addr 3; 0x00,0xBB x3,0xAA -> tx 0x55, busy low after the send.
// - Preload addr 0..99 = i; 0x00,0xCC with tx_ready always 1 -> 100 tx_starts 0..99, each >= GAP_CYC+2 clks apart; pointer = 100.
// - 0xA5,(DEPTH-2 lo),(hi); 0xCC -> tx data [DEPTH-2], [DEPTH-1], [0], ...; pointer = SHORT_LEN-2.
// - 0x33, then 0x55 after 5 bytes with tx_ready held low -> exactly 5 tx_starts; IDLE; busy = 0.
// - Assert rst mid-burst and mid-WR_DATA -> outputs at reset values the same clk, pointer 0, no ram_we.

Source files
------------

// File: rtl/uart_frame_cmd_ctrl.sv
// uart_frame_cmd_ctrl
//
// Byte-command controller sitting between the UART core and a single-port frame RAM
// (camera frame buffer). Received bytes are decoded in IDLE into pointer moves, pointer
// readback, single RAM reads/writes and paced read bursts. The pointer always stays
// below DEPTH and wraps DEPTH-1 -> 0.
//
// Parameters
//   ADDR_W     RAM address width; also the burst counter width
//   DEPTH      RAM words in use (DEPTH <= 2**ADDR_W)
//   SHORT_LEN  length of the 0xCC burst
//   GAP_CYC    idle cycles inserted between burst bytes (0 = back-to-back on tx_ready)
//
// Ports
//   clk_i        system clock
//   rst_i        asynchronous active-high reset
//   rx_valid_i   1-cycle pulse, rx_data_i holds a received byte
//   rx_data_i    received byte
//   tx_ready_i   UART transmitter idle, may accept tx_start_o
//   tx_start_o   1-cycle pulse, transmit tx_data_o
//   tx_data_o    byte to transmit, held until the next tx_start_o
//   ram_addr_o   RAM address (the internal pointer)
//   ram_wdata_o  RAM write data
//   ram_we_o     1-cycle RAM write strobe
//   ram_rdata_i  RAM read data, valid one clock after ram_addr_o changes
//   busy_o       high whenever the controller is not in IDLE
//
// Commands accepted in IDLE
//   0x00 pointer = 0          0xBB pointer + 1 (wrap)
//   0xFF send pointer[7:0]    0xFE send pointer[ADDR_W-1:8] zero-padded
//   0xA5 load 16-bit address (lo byte, then hi byte; >= DEPTH loads 0)
//   0xDD write next byte at pointer, then pointer + 1
//   0xAA read byte at pointer and send it
//   0xCC burst of SHORT_LEN   0x33 burst of DEPTH
//   0x55 aborts a pending send or burst; inside an address/data payload it is plain data.

module uart_frame_cmd_ctrl #(
  parameter int unsigned ADDR_W    = 15,
  parameter int unsigned DEPTH     = 19200,
  parameter int unsigned SHORT_LEN = 100,
  parameter int unsigned GAP_CYC   = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  input  logic              tx_ready_i,
  output logic              tx_start_o,
  output logic [7:0]        tx_data_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [7:0]        ram_wdata_o,
  output logic              ram_we_o,
  input  logic [7:0]        ram_rdata_i,
  output logic              busy_o
);

  // Wide enough to hold GAP_CYC-1, the first value loaded into the gap counter.
  localparam int unsigned GapW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [7:0] CmdPtrClr = 8'h00;
  localparam logic [7:0] CmdPtrInc = 8'hBB;
  localparam logic [7:0] CmdSendLo = 8'hFF;
  localparam logic [7:0] CmdSendHi = 8'hFE;
  localparam logic [7:0] CmdAddr   = 8'hA5;
  localparam logic [7:0] CmdWrite  = 8'hDD;
  localparam logic [7:0] CmdRead   = 8'hAA;
  localparam logic [7:0] CmdShort  = 8'hCC;
  localparam logic [7:0] CmdFull   = 8'h33;
  localparam logic [7:0] CmdAbort  = 8'h55;

  typedef enum logic [3:0] {
    StIdle,
    StAddrLo,
    StAddrHi,
    StWrData,
    StWrCommit,
    StRdWait,
    StTxWait,
    StBurstRd,
    StBurstTx,
    StBurstGap
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [GapW-1:0]   gap_q;
  logic [7:0]        addr_lo_q;
  logic [7:0]        snd_q;
  logic              tx_start_q;
  logic [7:0]        tx_data_q;
  logic              ram_we_q;
  logic [7:0]        ram_wdata_q;

  logic [ADDR_W-1:0] ptr_inc;
  logic [15:0]       ld_val;
  logic              ld_ok;
  logic [7:0]        ptr_lo;
  logic [7:0]        ptr_hi;
  logic              abort;

  always_comb begin
    ptr_inc = (ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    ld_val  = {rx_data_i, addr_lo_q};
    ld_ok   = 32'(ld_val) < DEPTH;
    ptr_lo  = 8'(ptr_q);
    ptr_hi  = 8'(ptr_q >> 8);
    abort   = rx_valid_i && (rx_data_i == CmdAbort);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      cnt_q       <= '0;
      gap_q       <= '0;
      addr_lo_q   <= '0;
      snd_q       <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      tx_start_q <= 1'b0;
      ram_we_q   <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (rx_valid_i) begin
            case (rx_data_i)
              CmdPtrClr: ptr_q <= '0;
              CmdPtrInc: ptr_q <= ptr_inc;
              CmdSendLo: begin
                snd_q   <= ptr_lo;
                state_q <= StTxWait;
              end
              CmdSendHi: begin
                snd_q   <= ptr_hi;
                state_q <= StTxWait;
              end
              CmdAddr:  state_q <= StAddrLo;
              CmdWrite: state_q <= StWrData;
              CmdRead:  state_q <= StRdWait;
              CmdShort: begin
                cnt_q   <= ADDR_W'(SHORT_LEN - 1);
                state_q <= StBurstRd;
              end
              CmdFull: begin
                cnt_q   <= ADDR_W'(DEPTH - 1);
                state_q <= StBurstRd;
              end
              default: ;
            endcase
          end
        end

        // The low byte is held aside so the pointer never shows an out-of-range
        // intermediate value; the full address is committed with the high byte.
        StAddrLo: begin
          if (rx_valid_i) begin
            addr_lo_q <= rx_data_i;
            state_q   <= StAddrHi;
          end
        end

        StAddrHi: begin
          if (rx_valid_i) begin
            ptr_q   <= ld_ok ? ADDR_W'(ld_val) : '0;
            state_q <= StIdle;
          end
        end

        StWrData: begin
          if (rx_valid_i) begin
            ram_wdata_q <= rx_data_i;
            ram_we_q    <= 1'b1;
            state_q     <= StWrCommit;
          end
        end

        // ram_we_o is high during this cycle at the old pointer; advance afterwards.
        StWrCommit: begin
          ptr_q   <= ptr_inc;
          state_q <= StIdle;
        end

        StRdWait: begin
          snd_q   <= ram_rdata_i;
          state_q <= StTxWait;
        end

        StTxWait: begin
          if (abort) begin
            state_q <= StIdle;
          end else if (tx_ready_i) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= snd_q;
            state_q    <= StIdle;
          end
        end

        // One cycle for ram_rdata_i to catch up with a freshly moved pointer.
        StBurstRd: begin
          state_q <= abort ? StIdle : StBurstTx;
        end

        StBurstTx: begin
          if (abort) begin
            state_q <= StIdle;
          end else if (tx_ready_i) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= ram_rdata_i;
            ptr_q      <= ptr_inc;
            if (cnt_q == '0) begin
              state_q <= StIdle;
            end else begin
              cnt_q <= cnt_q - 1'b1;
              if (GAP_CYC == 0) begin
                state_q <= StBurstRd;
              end else begin
                gap_q   <= GapW'(GAP_CYC - 1);
                state_q <= StBurstGap;
              end
            end
          end
        end

        StBurstGap: begin
          if (abort) begin
            state_q <= StIdle;
          end else if (gap_q == '0) begin
            state_q <= StBurstRd;
          end else begin
            gap_q <= gap_q - 1'b1;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign tx_start_o  = tx_start_q;
  assign tx_data_o   = tx_data_q;
  assign ram_addr_o  = ptr_q;
  assign ram_wdata_o = ram_wdata_q;
  assign ram_we_o    = ram_we_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_frame_cmd_ctrl.sv
// Self-checking bench for uart_frame_cmd_ctrl: a command table with expected pointer and
// expected transmit/write records, followed by hand-written burst, abort and reset
// sequences. Transmitted bytes and RAM writes are checked against scoreboard queues.

module tb_uart_frame_cmd_ctrl;

  localparam int ADDR_W    = 15;
  localparam int DEPTH     = 19200;
  localparam int SHORT_LEN = 100;
  localparam int GAP_CYC   = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              tx_ready = 1'b1;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic              ram_we;
  logic [7:0]        ram_rdata;
  logic              busy;

  logic [7:0] mem [DEPTH];

  typedef struct {
    int          n;
    logic [31:0] bytes;  // first byte sent is bytes[7:0]
    int          tx;     // expected transmitted byte, -1 = none
    int          wa;     // expected write address, -1 = none
    int          wd;
    int          ptr;    // expected pointer afterwards
  } vec_t;

  localparam int NV = 26;
  vec_t tbl [NV];

  logic [7:0]  exp_tx [$];
  logic [22:0] exp_wr [$];

  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_tx = 0;
  int   cyc = 0;
  int   last_tx = -1;
  bit   chk_gap = 1'b0;
  bit   tx_prev = 1'b0;
  bit   we_prev = 1'b0;
  logic [7:0]  e_tx;
  logic [22:0] e_wr;

  always #5 clk = ~clk;

  uart_frame_cmd_ctrl #(
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .SHORT_LEN (SHORT_LEN),
    .GAP_CYC   (GAP_CYC)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rx_valid_i  (rx_valid),
    .rx_data_i   (rx_data),
    .tx_ready_i  (tx_ready),
    .tx_start_o  (tx_start),
    .tx_data_o   (tx_data),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_we_o    (ram_we),
    .ram_rdata_i (ram_rdata),
    .busy_o      (busy)
  );

  // Single-port RAM with registered read.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  function automatic logic [7:0] f(input int i);
    return 8'(i) ^ 8'(i >> 8);
  endfunction

  // Output monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (tx_start) begin
        n_tx++;
        if (chk_gap && last_tx >= 0) begin
          n_cmp++;
          if (cyc - last_tx < GAP_CYC + 2) begin
            n_fail++;
            $display("FAIL burst spacing: got %0d clks, need >= %0d", cyc - last_tx,
                     GAP_CYC + 2);
          end
        end
        last_tx = cyc;
        n_cmp++;
        if (exp_tx.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected tx_start: data %02h, none expected", tx_data);
        end else begin
          e_tx = exp_tx.pop_front();
          if (tx_data !== e_tx) begin
            n_fail++;
            $display("FAIL tx_data: got %02h want %02h", tx_data, e_tx);
          end
        end
      end
      if (ram_we) begin
        n_cmp++;
        if (exp_wr.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected ram_we: addr %0h data %02h, none expected", ram_addr,
                   ram_wdata);
        end else begin
          e_wr = exp_wr.pop_front();
          if ({ram_addr, ram_wdata} !== e_wr) begin
            n_fail++;
            $display("FAIL ram write: got %0h/%02h want %0h/%02h", ram_addr, ram_wdata,
                     e_wr[22:8], e_wr[7:0]);
          end
        end
      end
      if ((tx_start && we_prev) || (ram_we && tx_prev)) begin
        n_cmp++;
        n_fail++;
        $display("FAIL strobe spacing: tx_start/ram_we in consecutive clks");
      end
      if (32'(ram_addr) >= DEPTH) begin
        n_cmp++;
        n_fail++;
        $display("FAIL pointer range: got %0h want < %0h", ram_addr, DEPTH);
      end
      tx_prev = tx_start;
      we_prev = ram_we;
    end else begin
      tx_prev = 1'b0;
      we_prev = 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max, input string nm);
    int k = 0;
    while (busy && k < max) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s timeout: busy still 1 after %0d clks, want 0", nm, max);
    end
    @(negedge clk);
  endtask

  task automatic wait_tx(input int base, input int n, input int max, input string nm);
    int k = 0;
    while (n_tx - base < n && k < max) begin
      @(negedge clk);
      k++;
    end
    if (n_tx - base < n) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s timeout: got %0d tx_starts want %0d", nm, n_tx - base, n);
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, " tx_start"}, 32'(tx_start), 0);
    chk({nm, " tx_data"}, 32'(tx_data), 0);
    chk({nm, " ram_we"}, 32'(ram_we), 0);
    chk({nm, " ram_wdata"}, 32'(ram_wdata), 0);
    chk({nm, " busy"}, 32'(busy), 0);
    chk({nm, " ram_addr"}, 32'(ram_addr), 0);
  endtask

  task automatic preload();
    for (int i = 0; i < DEPTH; i++) mem[i] = f(i);
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset(nm);
    exp_tx.delete();
    exp_wr.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int base;
    logic [31:0] b;

    tbl[0]  = '{1, 32'h00,       -1, -1, 0,    'h0};
    tbl[1]  = '{1, 32'hBB,       -1, -1, 0,    'h1};
    tbl[2]  = '{1, 32'hFF,       'h01, -1, 0,  'h1};
    tbl[3]  = '{3, 32'h0010A5,   -1, -1, 0,    'h10};
    tbl[4]  = '{2, 32'h5ADD,     -1, 'h10, 'h5A, 'h11};
    tbl[5]  = '{1, 32'hFF,       'h11, -1, 0,  'h11};
    tbl[6]  = '{3, 32'h1234A5,   -1, -1, 0,    'h1234};
    tbl[7]  = '{1, 32'hFE,       'h12, -1, 0,  'h1234};
    tbl[8]  = '{3, 32'h4AFFA5,   -1, -1, 0,    'h4AFF};
    tbl[9]  = '{1, 32'hFF,       'hFF, -1, 0,  'h4AFF};
    tbl[10] = '{1, 32'hBB,       -1, -1, 0,    'h0};
    tbl[11] = '{3, 32'h4AFEA5,   -1, -1, 0,    'h4AFE};
    tbl[12] = '{3, 32'h4B00A5,   -1, -1, 0,    'h0};
    tbl[13] = '{1, 32'hBB,       -1, -1, 0,    'h1};
    tbl[14] = '{1, 32'h77,       -1, -1, 0,    'h1};
    tbl[15] = '{1, 32'h55,       -1, -1, 0,    'h1};
    tbl[16] = '{3, 32'h0003A5,   -1, -1, 0,    'h3};
    tbl[17] = '{2, 32'h55DD,     -1, 'h3, 'h55, 'h4};
    tbl[18] = '{4, 32'hBBBBBB00, -1, -1, 0,    'h3};
    tbl[19] = '{1, 32'hAA,       'h55, -1, 0,  'h3};
    tbl[20] = '{3, 32'h0055A5,   -1, -1, 0,    'h55};
    tbl[21] = '{1, 32'hFF,       'h55, -1, 0,  'h55};
    tbl[22] = '{1, 32'hAA,       'h55, -1, 0,  'h55};
    tbl[23] = '{1, 32'hFE,       'h00, -1, 0,  'h55};
    tbl[24] = '{3, 32'h0010A5,   -1, -1, 0,    'h10};
    tbl[25] = '{1, 32'hAA,       'h5A, -1, 0,  'h10};

    preload();
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;

    // Command table
    for (int i = 0; i < NV; i++) begin
      if (tbl[i].wa >= 0) exp_wr.push_back({15'(tbl[i].wa), 8'(tbl[i].wd)});
      if (tbl[i].tx >= 0) exp_tx.push_back(8'(tbl[i].tx));
      b = tbl[i].bytes;
      for (int k = 0; k < tbl[i].n; k++) send(b[8*k +: 8]);
      wait_idle(50, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d pointer", i), 32'(ram_addr), 32'(tbl[i].ptr));
    end
    chk("table tx queue drained", exp_tx.size(), 0);
    chk("table wr queue drained", exp_wr.size(), 0);

    // tx_ready pacing of a single send
    tx_ready = 1'b0;
    base = n_tx;
    exp_tx.push_back(8'h10);
    send(8'hFF);
    repeat (10) @(negedge clk);
    chk("held send busy", 32'(busy), 1);
    chk("held send no tx", n_tx - base, 0);
    tx_ready = 1'b1;
    wait_idle(20, "held send");
    chk("held send tx count", n_tx - base, 1);

    // Abort beats a same-cycle send in TX_WAIT
    tx_ready = 1'b0;
    base = n_tx;
    send(8'hFF);
    @(negedge clk);
    tx_ready = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort priority no tx", n_tx - base, 0);
    chk("abort priority busy", 32'(busy), 0);

    // Short burst from 0, paced by GAP_CYC
    preload();
    for (int i = 0; i < SHORT_LEN; i++) exp_tx.push_back(f(i));
    base = n_tx;
    last_tx = -1;
    chk_gap = 1'b1;
    send(8'h00);
    send(8'hCC);
    wait_idle(SHORT_LEN * (GAP_CYC + 4) + 50, "burst0");
    chk_gap = 1'b0;
    chk("burst0 count", n_tx - base, SHORT_LEN);
    chk("burst0 pointer", 32'(ram_addr), SHORT_LEN);
    chk("burst0 queue drained", exp_tx.size(), 0);

    // Short burst across the DEPTH wrap
    send(8'hA5);
    send(8'(DEPTH - 2));
    send(8'((DEPTH - 2) >> 8));
    for (int i = 0; i < SHORT_LEN; i++) exp_tx.push_back(f((DEPTH - 2 + i) % DEPTH));
    base = n_tx;
    send(8'hCC);
    wait_idle(SHORT_LEN * (GAP_CYC + 4) + 50, "burst wrap");
    chk("burst wrap count", n_tx - base, SHORT_LEN);
    chk("burst wrap pointer", 32'(ram_addr), SHORT_LEN - 2);
    chk("burst wrap queue drained", exp_tx.size(), 0);

    // Full burst aborted after 5 bytes with tx_ready low
    send(8'h00);
    for (int i = 0; i < 5; i++) exp_tx.push_back(f(i));
    base = n_tx;
    send(8'h33);
    wait_tx(base, 5, 5 * (GAP_CYC + 4) + 50, "abort burst");
    tx_ready = 1'b0;
    send(8'h55);
    repeat (100) @(negedge clk);
    chk("abort burst count", n_tx - base, 5);
    chk("abort burst busy", 32'(busy), 0);
    chk("abort burst pointer", 32'(ram_addr), 5);
    tx_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort burst stays idle", n_tx - base, 5);

    // Reset in the middle of a burst
    for (int i = 5; i < 5 + SHORT_LEN; i++) exp_tx.push_back(f(i));
    base = n_tx;
    send(8'hCC);
    wait_tx(base, 3, 3 * (GAP_CYC + 4) + 50, "reset burst");
    do_reset("reset mid-burst");
    base = n_tx;
    repeat (3 * (GAP_CYC + 4)) @(negedge clk);
    chk("reset mid-burst no tx", n_tx - base, 0);

    // Reset in the middle of WR_DATA
    exp_wr.push_back({15'h0, 8'h3C});
    send(8'hDD);
    send(8'h3C);
    wait_idle(10, "write before reset");
    send(8'hDD);
    chk("wr_data busy", 32'(busy), 1);
    do_reset("reset mid-write");
    send(8'h77);
    repeat (5) @(negedge clk);
    chk("after reset busy", 32'(busy), 0);
    chk("after reset pointer", 32'(ram_addr), 0);
    chk("final wr queue drained", exp_wr.size(), 0);
    chk("final tx queue drained", exp_tx.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
